adc_sar_fsm: RTL and testbench
==============================

# adc_sar_fsm

Successive-approximation control FSM for the 12-bit capacitive SAR ADC. It produces the binary trial code that feeds the row/column/bincap thermometer decoder of the capacitor matrix, strobes the comparator, and resolves one bit per step from MSB to LSB. It then presents the settled 12-bit result with a one-cycle completion pulse. It sits between the digital start/readout interface and the capacitor DAC decoder.

## Interface
- `SAMPLE_CYCLES`, default 2: cycles `sample_out` is held high; legal range 1..255.
- `SETTLE_CYCLES`, default 1: DAC settling cycles before each comparator strobe; legal range 0..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_conv_in`  in  1  conversion request; level-sampled, accepted only in IDLE.
- `comp_in`  in  1  comparator result; 1 means Vin ≥ DAC, so the trial bit is kept.
- `data_out`  out  12  trial code to the DAC decoder: [11:8] row, [7:3] column, [2:0] bincap.
- `sample_out`  out  1  input sampling switch enable.
- `comp_trig_out`  out  1  comparator latch strobe.
- `result_out`  out  12  last completed conversion result.
- `conv_finished_out`  out  1  one-cycle pulse when `result_out` updates.
- `busy_out`  out  1  high while a conversion is in progress.

## Operation
- States: IDLE, SAMPLE, SETTLE, COMPARE, LATCH, DONE.
- Internal registers:
  - 4-bit bit index `k` (11..0).
  - 8-bit wait counter.
  - 12-bit SAR register; `data_out` is this register directly.
- IDLE:
  - If `start_conv_in` = 1, go to SAMPLE: SAR ← 12'h800, `k` ← 11, counter ← 0.
  - `data_out` holds the last SAR value.
- SAMPLE:
  - `sample_out` = 1 for exactly `SAMPLE_CYCLES` cycles.
  - Then go to SETTLE, or directly to COMPARE if `SETTLE_CYCLES` = 0.
- SETTLE: lasts `SETTLE_CYCLES` cycles, then go to COMPARE.
- COMPARE: `comp_trig_out` = 1 for one cycle, then go to LATCH.
- LATCH:
  - On the edge ending LATCH, `comp_in` is sampled.
  - SAR[k] ← `comp_in`.
  - If `k` > 0: SAR[k-1] ← 1, `k` ← `k`-1, go to SETTLE/COMPARE.
  - Else go to DONE.
- DONE:
  - `result_out` ← SAR, registered on entry so it is valid during the DONE cycle.
  - `conv_finished_out` = 1 for this one cycle.
  - Always returns to IDLE; `start_conv_in` is ignored in DONE.
- `busy_out` = 1 in every state except IDLE.
- `start_conv_in` is ignored outside IDLE; it never restarts or extends a conversion.
- `result_out` changes only on DONE entry; it is stable throughout the following conversion.
- Reset values, applied asynchronously and immediately, including mid-conversion:
  - State IDLE.
  - `data_out` = 12'h000, `result_out` = 12'h000.
  - `sample_out`, `comp_trig_out`, `conv_finished_out`, `busy_out` = 0.
  - The counter and `k` are cleared.
  - A conversion interrupted by reset produces no `conv_finished_out` and leaves `result_out` at 0.
- All outputs are registered or decoded from registered state only; no combinational path from `comp_in` or `start_conv_in` to any output.

## Timing
- Cycle 0 is the IDLE cycle in which `start_conv_in` is sampled high.
- SAMPLE occupies cycles 1..S, where S = `SAMPLE_CYCLES` and W = `SETTLE_CYCLES`.
- Each bit step takes W+2 cycles (W settle, 1 COMPARE, 1 LATCH).
- `data_out` updates at the start of the step's first cycle and is constant across that step.
- `conv_finished_out` is high in cycle 1+S+12·(W+2). With defaults this is cycle 39.
- The following IDLE is cycle 2+S+12·(W+2). With `start_conv_in` held high, the conversion period is S+12·(W+2)+2, which is 40 cycles with defaults.
- `comp_in` must be stable from the COMPARE cycle through the LATCH edge; its value during COMPARE is not used.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously between edges.
  - Required response: all outputs 0 without waiting for a clock edge; after release, IDLE with `busy_out` = 0.
- Conversion, defaults:
  - Stimulus: comparator model `comp_in` = (12'hA5C ≥ `data_out`); pulse start.
  - Required response: `data_out` trial sequence begins 12'h800, 12'hC00, 12'hA00. `conv_finished_out` high exactly in cycle 39 with `result_out` = 12'hA5C. `sample_out` high in cycles 1–2 only. Exactly 12 `comp_trig_out` pulses.
- Extremes:
  - `comp_in` stuck 1 → `result_out` = 12'hFFF.
  - `comp_in` stuck 0 → `result_out` = 12'h000.
  - In both cases the trial codes are 800, C00, E00…, or 800, 400, 200… respectively.
- Start handling:
  - Extra start pulses during bit 6 → no effect on timing or result.
  - `start_conv_in` held high → finishes in cycles 39 and 79, i.e. a period of 40.
- Reset mid-conversion:
  - Stimulus: `rst` during bit 5 COMPARE.
  - Required response: no finish pulse and `result_out` = 0. A new start after release yields the correct result at cycle 39.
- Parameters:
  - Stimulus: `SAMPLE_CYCLES` = 1, `SETTLE_CYCLES` = 0, Vin code 12'h3A7.
  - Required response: finish in cycle 26 with `result_out` = 12'h3A7. Period 27 when start is held.

Source files
------------

// File: rtl/adc_sar_fsm_if.sv
// Signal bundle between the SAR control FSM and its start/comparator/DAC neighbours.
// master drives the request and the comparator decision; slave is the FSM itself.
interface adc_sar_fsm_if;
  logic        start_conv_in;
  logic        comp_in;
  logic [11:0] data_out;
  logic        sample_out;
  logic        comp_trig_out;
  logic [11:0] result_out;
  logic        conv_finished_out;
  logic        busy_out;

  modport master (
    output start_conv_in,
    output comp_in,
    input  data_out,
    input  sample_out,
    input  comp_trig_out,
    input  result_out,
    input  conv_finished_out,
    input  busy_out
  );

  modport slave (
    input  start_conv_in,
    input  comp_in,
    output data_out,
    output sample_out,
    output comp_trig_out,
    output result_out,
    output conv_finished_out,
    output busy_out
  );
endinterface

// File: rtl/adc_sar_fsm.sv
// Successive-approximation control FSM for the 12-bit capacitive SAR ADC.
// Resolves one bit per SETTLE_CYCLES+2 cycles, MSB first; start is only honoured in IDLE.
module adc_sar_fsm #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  adc_sar_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    COMPARE,
    LATCH,
    DONE
  } state_t;

  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  // With no settling time each bit step starts straight at the comparator strobe.
  localparam state_t STEP_FIRST = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  k_q, k_d;
  logic [11:0] sar_q, sar_d;
  logic [11:0] res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      sar_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      sar_q   <= sar_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    sar_d   = sar_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_conv_in) begin
          state_d = SAMPLE;
          sar_d   = 12'h800;
          k_d     = 4'd11;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          state_d = STEP_FIRST;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      COMPARE: state_d = LATCH;
      LATCH: begin
        sar_d[k_q] = bus.comp_in;
        if (k_q != 4'd0) begin
          sar_d[k_q - 4'd1] = 1'b1;
          k_d               = k_q - 4'd1;
          state_d           = STEP_FIRST;
        end else begin
          // Result is captured on the DONE-entry edge so it is valid with the pulse.
          res_d   = sar_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out          = sar_q;
  assign bus.result_out        = res_q;
  assign bus.sample_out        = (state_q == SAMPLE);
  assign bus.comp_trig_out     = (state_q == COMPARE);
  assign bus.conv_finished_out = (state_q == DONE);
  assign bus.busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sar_fsm.sv
// Runs a default-parameter and a fast-parameter FSM side by side against a cycle-level
// timing model derived from the conversion schedule and a binary-search result model.
module tb_adc_sar_fsm;
  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [11:0] vin   = '0;
  int          mode  = 0;   // 0: comparator model, 1: stuck at 1, 2: stuck at 0
  int          n_chk = 0;
  int          n_err = 0;

  localparam int SC[2] = '{2, 1};
  localparam int WC[2] = '{1, 0};

  logic [11:0] trials[12];
  logic [11:0] final_code;
  logic [11:0] exp_dat[2];
  logic [11:0] exp_res[2];
  int          fin_q[2][$];
  int          res_q[2][$];
  int          trig_q[2][$];

  always #5 clk = ~clk;

  adc_sar_fsm_if ifa ();
  adc_sar_fsm_if ifb ();

  assign ifa.start_conv_in = start;
  assign ifb.start_conv_in = start;
  assign ifa.comp_in = (mode == 1) | ((mode == 0) & (vin >= ifa.data_out));
  assign ifb.comp_in = (mode == 1) | ((mode == 0) & (vin >= ifb.data_out));

  adc_sar_fsm #(.SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) u_dflt (.clk(clk), .rst(rst), .bus(ifa.slave));
  adc_sar_fsm #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_fast (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {busy, sample, trig, finished, data_out, result_out}
  function automatic logic [27:0] observe(input int i);
    if (i == 0)
      return {ifa.busy_out, ifa.sample_out, ifa.comp_trig_out, ifa.conv_finished_out,
              ifa.data_out, ifa.result_out};
    return {ifb.busy_out, ifb.sample_out, ifb.comp_trig_out, ifb.conv_finished_out,
            ifb.data_out, ifb.result_out};
  endfunction

  function automatic int at(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic build_model(input logic [11:0] code, input int md);
    logic [11:0] acc;
    logic [11:0] trial;
    acc = '0;
    for (int j = 0; j < 12; j++) begin
      trial     = acc | (12'h800 >> j);
      trials[j] = trial;
      if (md == 1 || (md == 0 && code >= trial)) acc = trial;
    end
    final_code = acc;
  endtask

  task automatic model(input int i, input int c, input int len, input bit hold,
                       output logic [27:0] e);
    int P, n, p, j, r;
    logic b, s, t, f;
    P = SC[i] + 12 * (WC[i] + 2) + 2;
    n = c / P;
    p = c % P;
    b = 1'b0; s = 1'b0; t = 1'b0; f = 1'b0;
    if ((n == 0 || (hold && n * P < len)) && p >= 1) begin
      b = 1'b1;
      if (p <= SC[i]) begin
        s          = 1'b1;
        exp_dat[i] = 12'h800;
      end else if (p <= SC[i] + 12 * (WC[i] + 2)) begin
        j          = (p - SC[i] - 1) / (WC[i] + 2);
        r          = (p - SC[i] - 1) % (WC[i] + 2);
        t          = (r == WC[i]);
        exp_dat[i] = trials[j];
      end else begin
        f          = 1'b1;
        exp_dat[i] = final_code;
        exp_res[i] = final_code;
      end
    end
    e = {b, s, t, f, exp_dat[i], exp_res[i]};
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    start = 1'b0;
    #1;
    check("rst_async_u0", observe(0), '0);
    check("rst_async_u1", observe(1), '0);
    @(negedge clk);
    rst = 1'b0;
    exp_dat = '{default: '0};
    exp_res = '{default: '0};
    @(negedge clk);
    check("rst_idle_u0", observe(0), '0);
    check("rst_idle_u1", observe(1), '0);
  endtask

  // Entered at a negedge; that cycle is cycle 0 with start high.
  task automatic run(input logic [11:0] code, input int md, input int len, input bit hold,
                     input int gl_lo, input int gl_hi, input int rst_at);
    logic [27:0] e;
    logic [27:0] o;
    vin  = code;
    mode = md;
    build_model(code, md);
    for (int i = 0; i < 2; i++) begin
      fin_q[i].delete();
      res_q[i].delete();
      trig_q[i].delete();
    end
    start = 1'b1;
    for (int c = 1; c <= len + 45; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        do_reset();
        return;
      end
      for (int i = 0; i < 2; i++) begin
        model(i, c, len, hold, e);
        o = observe(i);
        check($sformatf("cyc%0d_u%0d", c, i), o, e);
        if (o[24]) begin
          fin_q[i].push_back(c);
          res_q[i].push_back(int'(o[11:0]));
        end
        if (o[25]) trig_q[i].push_back(int'(o[23:12]));
      end
      start = (hold && c + 1 < len) || (c + 1 >= gl_lo && c + 1 <= gl_hi);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [11:0] code;
    exp_dat = '{default: '0};
    exp_res = '{default: '0};
    #2;
    check("por_u0", observe(0), '0);
    check("por_u1", observe(1), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_u0", observe(0), '0);

    run(12'hA5C, 0, 45, 1'b0, -1, -1, -1);
    check("a5c_fin_u0", 28'(at(fin_q[0], 0)), 28'd39);
    check("a5c_fin_u1", 28'(at(fin_q[1], 0)), 28'd26);
    check("a5c_res_u0", 28'(at(res_q[0], 0)), 28'hA5C);
    check("a5c_ntrig_u0", 28'(trig_q[0].size()), 28'd12);
    check("a5c_trial0", 28'(at(trig_q[0], 0)), 28'h800);
    check("a5c_trial1", 28'(at(trig_q[0], 1)), 28'hC00);
    check("a5c_trial2", 28'(at(trig_q[0], 2)), 28'hA00);

    run(12'h000, 1, 45, 1'b0, -1, -1, -1);
    check("stk1_res", 28'(at(res_q[0], 0)), 28'hFFF);
    check("stk1_trial2", 28'(at(trig_q[0], 2)), 28'hE00);

    run(12'hFFF, 2, 45, 1'b0, -1, -1, -1);
    check("stk0_res", 28'(at(res_q[0], 0)), 28'h000);
    check("stk0_trial1", 28'(at(trig_q[0], 1)), 28'h400);
    check("stk0_trial2", 28'(at(trig_q[0], 2)), 28'h200);

    code = 12'($urandom_range(0, 4095));
    run(code, 0, 45, 1'b0, 18, 20, -1);
    check("glitch_fin", 28'(at(fin_q[0], 0)), 28'd39);
    check("glitch_nfin", 28'(fin_q[0].size()), 28'd1);
    check("glitch_res", 28'(at(res_q[0], 0)), 28'(code));

    code = 12'($urandom_range(0, 4095));
    run(code, 0, 80, 1'b1, -1, -1, -1);
    check("hold_fin0_u0", 28'(at(fin_q[0], 0)), 28'd39);
    check("hold_fin1_u0", 28'(at(fin_q[0], 1)), 28'd79);
    check("hold_fin1_u1", 28'(at(fin_q[1], 1)), 28'd53);

    code = 12'($urandom_range(0, 4095));
    run(code, 0, 45, 1'b0, -1, -1, 22);
    check("rst_nofin_u0", 28'(fin_q[0].size()), 28'd0);
    check("rst_nofin_u1", 28'(fin_q[1].size()), 28'd0);
    code = 12'($urandom_range(0, 4095));
    run(code, 0, 45, 1'b0, -1, -1, -1);
    check("post_rst_fin", 28'(at(fin_q[0], 0)), 28'd39);
    check("post_rst_res", 28'(at(res_q[0], 0)), 28'(code));

    run(12'h3A7, 0, 45, 1'b0, -1, -1, -1);
    check("fast_fin", 28'(at(fin_q[1], 0)), 28'd26);
    check("fast_res", 28'(at(res_q[1], 0)), 28'h3A7);

    for (int n = 0; n < 6; n++) begin
      code = 12'($urandom_range(0, 4095));
      run(code, 0, 45, 1'b0, -1, -1, -1);
      check($sformatf("rand%0d_res_u0", n), 28'(at(res_q[0], 0)), 28'(code));
      check($sformatf("rand%0d_res_u1", n), 28'(at(res_q[1], 0)), 28'(code));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
